// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the PISO serializer: FSM state encoding and
// the bit-counter width derived from the word width.
package piso_serializer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Word-in / bit-out bus of the PISO serializer. The master drives the word
// and the bit tick; the slave (the serializer) returns ready and the serial stream.
interface piso_serializer_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             bit_en;
  logic             ser_data;
  logic             ser_valid;
  logic             ser_last;

  modport master (
    output in_valid, in_data, bit_en,
    input  in_ready, ser_data, ser_valid, ser_last
  );

  modport slave (
    input  in_valid, in_data, bit_en,
    output in_ready, ser_data, ser_valid, ser_last
  );
endinterface

// File: rtl/piso_shift_reg.sv
// WIDTH-bit loadable shift register; shifts toward the head bit with zero
// fill. Head is the MSB when MSB_FIRST=1, else the LSB.
module piso_shift_reg #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift,
  output logic             head
);
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;

  always_comb begin
    shreg_d = shreg_q;
    if (load) begin
      shreg_d = load_data;
    end else if (shift) begin
      if (MSB_FIRST) shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
      else           shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) shreg_q <= '0;
    else       shreg_q <= shreg_d;
  end

  assign head = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: accepts one word on a valid/ready
// handshake, then presents one bit per bit_en-paced interval.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  piso_serializer_if.slave       bus
);
  localparam int unsigned    CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  CNT_LOAD = CW'(WIDTH - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          load;
  logic          shift;
  logic          head;
  logic          in_ready;
  logic          ser_valid;
  logic          ser_data;
  logic          ser_last;

  piso_shift_reg #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_shreg (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_data(bus.in_data),
    .shift    (shift),
    .head     (head)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    load      = 1'b0;
    shift     = 1'b0;
    in_ready  = 1'b0;
    ser_valid = 1'b0;
    ser_data  = 1'b0;
    ser_last  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          load    = 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        ser_valid = 1'b1;
        ser_data  = head;
        ser_last  = (cnt_q == '0);
        // The last bit leaves without shifting, so the counter parks at 0.
        if (bus.bit_en) begin
          if (cnt_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            shift = 1'b1;
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.in_ready  = in_ready;
  assign bus.ser_valid = ser_valid;
  assign bus.ser_data  = ser_data;
  assign bus.ser_last  = ser_last;
endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in, serial-out transmitter. Accepts one WIDTH-bit word through a valid/ready handshake, then shifts it out one bit per enabled cycle.
- Transmit-side counterpart to the serial-in flip-flop chains in the flip-flop assignment set. Its serial output feeds a deserializer/receiver built from the same DFF primitives.
- Bit rate is gated by an external bit_en tick, so a baud/prescaler counter can pace it.

Parameters:
- WIDTH, 8, word width in bits; legal range WIDTH >= 2.
- MSB_FIRST, 1, 1 = transmit in_data[WIDTH-1] first; 0 = transmit in_data[0] first.

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- reset  input  1  synchronous, active-high reset; sampled on rising clk only.
- in_valid  input  1  upstream word valid.
- in_data  input  WIDTH  parallel word; captured on handshake.
- in_ready  output  1  block can accept a word (IDLE state).
- bit_en  input  1  bit-advance tick; shift happens only on cycles with bit_en=1.
- ser_data  output  1  serial data bit.
- ser_valid  output  1  high while a frame is being transmitted.
- ser_last  output  1  high while the final bit of the frame is presented.

Behaviour:
- All outputs are registered or decoded from registered state only; there is no combinational path from inputs to outputs.
- Reset (reset=1 at a rising edge): state=IDLE, shift register=0, bit counter=0, in_ready=1, ser_data=0, ser_valid=0, ser_last=0.
- Reset has priority over every other event. A reset mid-frame discards the remaining bits, and outputs are at reset values on the following cycle.
- States: IDLE, SHIFT (2 states; encoding from package).
- IDLE:
  - in_ready=1, ser_valid=0, ser_data=0.
  - Handshake = in_valid & in_ready at a rising edge. On handshake, load in_data into the shift register, set counter=WIDTH-1, go to SHIFT.
  - bit_en is ignored in IDLE.
- SHIFT:
  - in_ready=0, ser_valid=1.
  - ser_data = current head bit: shreg[WIDTH-1] if MSB_FIRST=1, else shreg[0].
  - Latency: the first bit appears the cycle after the handshake edge, regardless of bit_en.
  - At an edge with bit_en=1 and counter != 0: shift toward the head (fill 0), counter decrements.
  - At an edge with bit_en=0: hold shift register, counter and outputs unchanged. The bit is stretched.
  - ser_last=1 whenever state=SHIFT and counter==0.
  - At an edge with bit_en=1 and counter==0: go to IDLE. in_ready=1 on the next cycle.
- Each bit is presented for at least 1 cycle, exactly (number of cycles until the next bit_en=1 edge, inclusive).
- in_valid while in SHIFT is ignored. in_data is not re-sampled and no word is queued.
- Back-to-back frames are not supported. There is a minimum 1 IDLE cycle between frames, so frame period >= WIDTH+1 cycles at bit_en=1 constant.
- Counter width: $clog2(WIDTH) bits. The counter never wraps; it stops at 0 on frame exit.
- X on in_data outside a handshake must not propagate to outputs.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE=1'b0 and ST_SHIFT=1'b1;
  - the counter-width function/constant derived from WIDTH.
- Natural sub-module: piso_shift_reg, a WIDTH-bit loadable shift register with ports clk, reset, load, load_data, shift, direction from MSB_FIRST, and a head output.
- The FSM, counter and handshake stay in piso_serializer.

Test Plan:
1. WIDTH=8, MSB_FIRST=1, bit_en=1 constant, in_data=8'h35 with in_valid one cycle.
   - Expected: ser_data=0,0,1,1,0,1,0,1 on 8 consecutive cycles starting the cycle after the handshake.
   - ser_valid high for exactly 8 cycles; ser_last high only on the 8th; in_ready=1 on the 9th.
2. MSB_FIRST=0, same stimulus.
   - Expected: ser_data=1,0,1,0,1,1,0,0 with the same timing.
3. bit_en high every other cycle, in_data=8'h96, MSB_FIRST=1.
   - Expected: each bit of 1,0,0,1,0,1,1,0 held exactly 2 cycles; ser_valid high 16 cycles.
4. in_valid held high continuously with in_data changing every cycle.
   - Expected: only the word at the first handshake is sent.
   - Expected: the next word is accepted only after 1 IDLE cycle; the frame-to-frame gap is exactly 1 cycle.
5. Assert reset=1 for 1 cycle after the 3rd bit of 8'hFF.
   - Expected: the next cycle has ser_valid=0, ser_data=0, ser_last=0, in_ready=1.
   - Expected: a new word 8'h01 then transmits correctly from bit 0.
6. Assert reset together with in_valid=1.
   - Expected: reset wins; no frame starts; in_ready=1, ser_valid=0 on the next cycle.
